// File: rtl/geofence_result_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : geofence_result_collector                                       |
// | Purpose  : Turns each rising edge of the geofence core's result strobe     |
// |            into a record {object index, inside flag}. Records are held in  |
// |            a show-ahead FIFO until the host drains them. The block also    |
// |            keeps saturating inside/outside tallies and a sticky overflow.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk         in   clock, rising edge                                      |
// |   reset       in   asynchronous active-high reset                          |
// |   valid       in   result strobe; one record per low-to-high transition    |
// |   is_inside   in   result bit, sampled with the strobe edge                |
// |   clr         in   synchronous clear of FIFO, tallies, index, overflow     |
// |   pop         in   host consumes the FIFO head                             |
// |   res_valid   out  FIFO not empty                                          |
// |   res_idx     out  object index of head entry (0 when empty)               |
// |   res_inside  out  inside flag of head entry (0 when empty)                |
// |   fill        out  FIFO occupancy                                          |
// |   inside_cnt  out  saturating count of inside results                      |
// |   outside_cnt out  saturating count of outside results                     |
// |   overflow    out  sticky; a record was dropped on a full FIFO             |
// +----------------------------------------------------------------------------+
module geofence_result_collector #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 8,
  parameter int CNT_W = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid,
  input  logic                     is_inside,
  input  logic                     clr,
  input  logic                     pop,
  output logic                     res_valid,
  output logic [IDX_W-1:0]         res_idx,
  output logic                     res_inside,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [CNT_W-1:0]         inside_cnt,
  output logic [CNT_W-1:0]         outside_cnt,
  output logic                     overflow
);

  localparam int                AW        = $clog2(DEPTH);
  localparam logic [AW:0]       FILL_FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic                 valid_d_q,  valid_d_d;
  logic [IDX_W-1:0]     obj_idx_q,  obj_idx_d;
  logic [CNT_W-1:0]     in_cnt_q,   in_cnt_d;
  logic [CNT_W-1:0]     out_cnt_q,  out_cnt_d;
  logic                 ovf_q,      ovf_d;
  logic [AW:0]          fill_q,     fill_d;
  logic [AW-1:0]        wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q,   rd_ptr_d;
  logic [IDX_W:0]       mem_q [DEPTH];

  logic                 ev_take;
  logic                 empty;
  logic                 full;
  logic                 do_pop;
  logic                 do_wr;
  logic                 drop;
  logic [IDX_W:0]       head;

  always_comb begin
    // An event landing on a clear cycle is discarded entirely.
    ev_take = valid & ~valid_d_q & ~clr;
    empty   = (fill_q == '0);
    full    = (fill_q == FILL_FULL);
    do_pop  = pop & ~empty;
    // A full FIFO is never empty, so a raw pop frees the slot being written.
    do_wr   = ev_take & (~full | pop);
    drop    = ev_take & full & ~pop;

    valid_d_d = valid;
    obj_idx_d = obj_idx_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    ovf_d     = ovf_q;
    fill_d    = fill_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    if (clr) begin
      obj_idx_d = '0;
      in_cnt_d  = '0;
      out_cnt_d = '0;
      ovf_d     = 1'b0;
      fill_d    = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
    end else begin
      if (do_wr)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_wr, do_pop})
        2'b10:   fill_d = fill_q + 1'b1;
        2'b01:   fill_d = fill_q - 1'b1;
        default: fill_d = fill_q;
      endcase
      // Index and tallies advance even when the record is dropped, so the
      // host can detect the loss as a gap in the index sequence.
      if (ev_take) begin
        obj_idx_d = obj_idx_q + 1'b1;
        if (is_inside) begin
          if (in_cnt_q != CNT_MAX) in_cnt_d = in_cnt_q + 1'b1;
        end else begin
          if (out_cnt_q != CNT_MAX) out_cnt_d = out_cnt_q + 1'b1;
        end
      end
      if (drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_d_q <= 1'b0;
      obj_idx_q <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      ovf_q     <= 1'b0;
      fill_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      valid_d_q <= valid_d_d;
      obj_idx_q <= obj_idx_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      ovf_q     <= ovf_d;
      fill_q    <= fill_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_wr) begin
      mem_q[wr_ptr_q] <= {obj_idx_q, is_inside};
    end
  end

  // Show-ahead head; forced to zero while empty so outputs are deterministic.
  assign head        = empty ? '0 : mem_q[rd_ptr_q];
  assign res_valid   = ~empty;
  assign res_idx     = head[IDX_W:1];
  assign res_inside  = head[0];
  assign fill        = fill_q;
  assign inside_cnt  = in_cnt_q;
  assign outside_cnt = out_cnt_q;
  assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_geofence_result_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_geofence_result_collector                                    |
// | Purpose  : Directed scoreboard bench for geofence_result_collector         |
// |            (DEPTH=8, IDX_W=8, CNT_W=3).                                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_geofence_result_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       is_inside = 1'b0;
  logic       clr = 1'b0;
  logic       pop = 1'b0;
  logic       res_valid;
  logic [7:0] res_idx;
  logic       res_inside;
  logic [3:0] fill;
  logic [2:0] inside_cnt;
  logic [2:0] outside_cnt;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int nidx   = 0;
  logic [8:0] sb [$];

  geofence_result_collector #(
    .DEPTH(8),
    .IDX_W(8),
    .CNT_W(3)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .valid      (valid),
    .is_inside  (is_inside),
    .clr        (clr),
    .pop        (pop),
    .res_valid  (res_valid),
    .res_idx    (res_idx),
    .res_inside (res_inside),
    .fill       (fill),
    .inside_cnt (inside_cnt),
    .outside_cnt(outside_cnt),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: whenever the host pops a non-empty FIFO, the head must match
  // the oldest expected record.
  always @(negedge clk) begin
    if (!rst && pop && res_valid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pop_idx", int'(res_idx), -1);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("head_idx", int'(res_idx), int'(e[8:1]));
        chk("head_inside", int'(res_inside), int'(e[0]));
      end
    end
  end

  task automatic drive(input logic v, input logic ins, input logic p, input logic c);
    @(posedge clk);
    #1;
    valid = v; is_inside = ins; pop = p; clr = c;
  endtask

  // One strobe: a valid-high cycle followed by a valid-low cycle.
  task automatic ev(input logic ins, input logic p0, input logic p1);
    drive(1'b1, ins, p0, 1'b0);
    drive(1'b0, 1'b0, p1, 1'b0);
  endtask

  task automatic push(input logic ins);
    logic [31:0] v;
    v = nidx;
    sb.push_back({v[7:0], ins});
    nidx++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; valid = 0; is_inside = 0; pop = 0; clr = 0;
    sb.delete();
    nidx = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_fill", int'(fill), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_idx", int'(res_idx), 0);
    chk("rst_inside_cnt", int'(inside_cnt), 0);
    chk("rst_outside_cnt", int'(outside_cnt), 0);
    chk("rst_overflow", int'(overflow), 0);
    @(posedge clk); #1; rst = 1'b0;

    // Long strobe: valid held two cycles gives a single record
    push(1'b1);
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("long_fill", int'(fill), 1);
    chk("long_res_valid", int'(res_valid), 1);
    chk("long_inside_cnt", int'(inside_cnt), 1);
    chk("long_outside_cnt", int'(outside_cnt), 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("long_fill_after_pop", int'(fill), 0);

    // Ordering: inside, outside, inside; pop three times then once more
    do_reset();
    push(1'b1); ev(1, 0, 0);
    push(1'b0); ev(0, 0, 0);
    push(1'b1); ev(1, 0, 0);
    @(negedge clk);
    chk("ord_fill", int'(fill), 3);
    repeat (3) drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("ord_res_valid_empty", int'(res_valid), 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("ord_fill_extra_pop", int'(fill), 0);
    chk("ord_res_valid_extra_pop", int'(res_valid), 0);
    chk("ord_inside_cnt", int'(inside_cnt), 2);
    chk("ord_outside_cnt", int'(outside_cnt), 1);

    // Overflow: eight fill the FIFO, ninth is dropped, tenth rides on a pop
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push(1'b0);
      ev(0, 0, 0);
    end
    @(negedge clk);
    chk("ovf_fill_full", int'(fill), 8);
    chk("ovf_not_yet", int'(overflow), 0);
    nidx++;
    ev(0, 0, 0);
    @(negedge clk);
    chk("ovf_fill_after_drop", int'(fill), 8);
    chk("ovf_set", int'(overflow), 1);
    push(1'b1);
    ev(1, 1, 0);
    @(negedge clk);
    chk("ovf_fill_write_on_pop", int'(fill), 8);
    repeat (8) drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("ovf_drained", int'(res_valid), 0);
    chk("ovf_sticky", int'(overflow), 1);
    chk("ovf_outside_sat", int'(outside_cnt), 7);
    chk("ovf_inside_cnt", int'(inside_cnt), 1);

    // Saturation: nine inside events with continuous popping
    do_reset();
    for (int i = 0; i < 9; i++) begin
      push(1'b1);
      ev(1, 1, 1);
    end
    push(1'b0);
    ev(0, 1, 1);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("sat_inside_cnt", int'(inside_cnt), 7);
    chk("sat_outside_cnt", int'(outside_cnt), 1);
    chk("sat_fill", int'(fill), 0);

    // Clear coinciding with an event, with fill=3 and overflow set
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i < 8) push(1'b0); else nidx++;
      ev(0, 0, 0);
    end
    repeat (5) drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("clr_fill_before", int'(fill), 3);
    sb.delete();
    drive(1, 1, 0, 1);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("clr_fill", int'(fill), 0);
    chk("clr_inside_cnt", int'(inside_cnt), 0);
    chk("clr_outside_cnt", int'(outside_cnt), 0);
    chk("clr_overflow", int'(overflow), 0);
    chk("clr_res_valid", int'(res_valid), 0);
    nidx = 0;
    push(1'b1);
    ev(1, 0, 0);
    @(negedge clk);
    chk("clr_next_fill", int'(fill), 1);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);

    // Asynchronous reset with five buffered records
    for (int i = 0; i < 5; i++) begin
      push(1'b1);
      ev(1, 0, 0);
    end
    @(negedge clk);
    chk("arst_fill_before", int'(fill), 5);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("arst_fill", int'(fill), 0);
    chk("arst_res_valid", int'(res_valid), 0);
    chk("arst_res_idx", int'(res_idx), 0);
    chk("arst_inside_cnt", int'(inside_cnt), 0);
    chk("arst_overflow", int'(overflow), 0);
    @(posedge clk); #1; rst = 1'b0; nidx = 0;
    drive(0, 0, 0, 0);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
